// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory-port arbiter:
// FSM state encoding, request op encoding, default parameter values.
package mem_arb_pkg;

    localparam int DEF_NUM_CH = 2;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } arb_op_e;

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational winner selection over the valid request slots.
// MEM_ARB_RR_EN selects round-robin from last_grant+1; otherwise lowest index wins.
module mem_arb_picker import mem_arb_pkg::*; #(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] slot_valid,
    input  logic [CH_W-1:0]   last_grant,
    output logic [CH_W-1:0]   winner,
    output logic              any_valid
);

    logic [CH_W-1:0] idx_s;

    assign any_valid = |slot_valid;

`ifdef MEM_ARB_RR_EN
    // Scan downward so the candidate closest after last_grant is written last and wins.
    always_comb begin
        winner = {CH_W{1'b0}};
        idx_s  = {CH_W{1'b0}};
        for (int k = NUM_CH; k >= 1; k--) begin
            idx_s  = CH_W'((int'(last_grant) + k) % NUM_CH);
            winner = slot_valid[idx_s] ? idx_s : winner;
        end
    end
`else
    logic unused_s;
    assign unused_s = ^last_grant;

    // Fixed priority: scan from the top so the lowest valid index is written last.
    always_comb begin
        winner = {CH_W{1'b0}};
        idx_s  = {CH_W{1'b0}};
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx_s  = CH_W'(i);
            winner = slot_valid[idx_s] ? idx_s : winner;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel memory-port arbiter: one-deep slot per channel, single outstanding
// busy/done transaction downstream. MEM_ARB_RR_EN enables round-robin arbitration.
module mem_port_arbiter import mem_arb_pkg::*; #(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    input  logic [NUM_CH*MASK_W-1:0] ch_mask,
    output logic [NUM_CH-1:0]        ch_busy,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [DATA_W-1:0]        ch_rdata,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [MASK_W-1:0]        mem_mask,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_busy,
    input  logic                     mem_done
);

    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0] slot_valid_r;
    arb_op_e           slot_op_r    [NUM_CH];
    logic [ADDR_W-1:0] slot_addr_r  [NUM_CH];
    logic [DATA_W-1:0] slot_wdata_r [NUM_CH];
    logic [MASK_W-1:0] slot_mask_r  [NUM_CH];

    arb_state_e        state_r;
    logic [CH_W-1:0]   grant_r;
    logic [CH_W-1:0]   winner_s;
    logic [CH_W-1:0]   last_grant_s;
    logic              any_valid_s;
    logic              finish_s;

    assign ch_busy  = slot_valid_r;
    assign finish_s = (state_r == WAIT) && mem_done;

    mem_arb_picker #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_picker (
        .slot_valid (slot_valid_r),
        .last_grant (last_grant_s),
        .winner     (winner_s),
        .any_valid  (any_valid_s)
    );

`ifdef MEM_ARB_RR_EN
    logic [CH_W-1:0] last_grant_r;

    // Round-robin pointer follows every grant issued from IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= CH_W'(NUM_CH - 1);
        end else if ((state_r == IDLE) && any_valid_s) begin
            last_grant_r <= winner_s;
        end
    end

    assign last_grant_s = last_grant_r;
`else
    assign last_grant_s = CH_W'(NUM_CH - 1);
`endif

    // Slot capture and release; capture only tests an idle slot, so it never races the release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid_r <= {NUM_CH{1'b0}};
            for (int i = 0; i < NUM_CH; i++) begin
                slot_op_r[i]    <= OP_READ;
                slot_addr_r[i]  <= {ADDR_W{1'b0}};
                slot_wdata_r[i] <= {DATA_W{1'b0}};
                slot_mask_r[i]  <= {MASK_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ((ch_read[i] | ch_write[i]) & ~slot_valid_r[i]) begin
                    slot_valid_r[i] <= 1'b1;
                    slot_op_r[i]    <= ch_write[i] ? OP_WRITE : OP_READ;
                    slot_addr_r[i]  <= ch_addr[i*ADDR_W +: ADDR_W];
                    slot_wdata_r[i] <= ch_wdata[i*DATA_W +: DATA_W];
                    slot_mask_r[i]  <= ch_mask[i*MASK_W +: MASK_W];
                end else if (finish_s && (grant_r == CH_W'(i))) begin
                    slot_valid_r[i] <= 1'b0;
                end
            end
        end
    end

    // Transaction FSM with registered memory-side and completion outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            grant_r   <= {CH_W{1'b0}};
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= {DATA_W{1'b0}};
            mem_mask  <= {MASK_W{1'b0}};
            ch_done   <= {NUM_CH{1'b0}};
            ch_rdata  <= {DATA_W{1'b0}};
        end else begin
            ch_done <= {NUM_CH{1'b0}};
            case (state_r)
                IDLE: begin
                    if (any_valid_s) begin
                        grant_r   <= winner_s;
                        mem_read  <= (slot_op_r[winner_s] == OP_READ);
                        mem_write <= (slot_op_r[winner_s] == OP_WRITE);
                        mem_addr  <= slot_addr_r[winner_s];
                        mem_wdata <= slot_wdata_r[winner_s];
                        mem_mask  <= slot_mask_r[winner_s];
                        state_r   <= REQ;
                    end
                end
                REQ: begin
                    // Request fields stay frozen until the memory accepts them.
                    if (!mem_busy) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state_r   <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_done) begin
                        if (slot_op_r[grant_r] == OP_READ) begin
                            ch_rdata <= mem_rdata;
                        end
                        ch_done[grant_r] <= 1'b1;
                        state_r          <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
